// File: rtl/mips_seq_shifter.sv
// Multi-cycle shifter for the MIPS EX stage: SLL/SRL/SRA (and optional ROTR), at most STEP bits per cycle.
// Optional rotate-right on op=11 is enabled by defining MIPS_SEQ_SHIFTER_ROTATE_EN; otherwise op=11 acts as SRL.
module mips_seq_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   data_in,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   data_out
);

  // One extra bit so that STEP==WIDTH and WIDTH-amt are representable.
  localparam int CNT_W = SHAMT_W + 1;
  localparam logic [CNT_W-1:0] STEP_C  = CNT_W'(STEP);
  localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           state;
  logic [1:0]       op_q;
  logic [CNT_W-1:0] remaining;
  logic [WIDTH-1:0] work;

  logic [CNT_W-1:0] amt;
  logic [CNT_W-1:0] rem_next;
  logic [WIDTH-1:0] work_next;
  logic             accept;

  // Partial shift of v by a; SRA keeps the sign because work keeps its MSB.
  function automatic logic [WIDTH-1:0] shift_step(
    input logic [WIDTH-1:0] v,
    input logic [1:0]       mode,
    input logic [CNT_W-1:0] a
  );
    logic signed [WIDTH-1:0] sv;
    logic [WIDTH-1:0]        r;
    sv = v;
    case (mode)
      2'b00:   r = v << a;
      2'b10:   r = $unsigned(sv >>> a);
`ifdef MIPS_SEQ_SHIFTER_ROTATE_EN
      2'b11:   r = (v >> a) | (v << (WIDTH_C - a));
`else
      2'b11:   r = v >> a;
`endif
      default: r = v >> a;
    endcase
    return r;
  endfunction

  always_comb begin
    amt       = (remaining > STEP_C) ? STEP_C : remaining;
    rem_next  = remaining - amt;
    work_next = shift_step(work, op_q, amt);
    accept    = start && (state == S_IDLE || state == S_DONE);
  end

  // Control and result register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      data_out  <= '0;
      remaining <= '0;
      op_q      <= 2'b00;
    end else begin
      done <= 1'b0;
      busy <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            op_q      <= op;
            remaining <= {1'b0, shamt};
            if (shamt == '0) begin
              data_out <= data_in;
              done     <= 1'b1;
              state    <= S_DONE;
            end else begin
              busy  <= 1'b1;
              state <= S_SHIFT;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          remaining <= rem_next;
          if (rem_next == '0) begin
            data_out <= work_next;
            done     <= 1'b1;
            state    <= S_DONE;
          end else begin
            busy <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Work register is pure datapath; its content is irrelevant outside SHIFT.
  always_ff @(posedge clk) begin
    if (accept) begin
      work <= data_in;
    end else if (state == S_SHIFT) begin
      work <= work_next;
    end
  end

endmodule

// File: tb/tb_mips_seq_shifter.sv
// Self-checking bench for mips_seq_shifter: vector table plus handshake corner sequences, scoreboard-checked.
module tb_mips_seq_shifter;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [4:0]  shamt;
  logic [31:0] data_in;
  logic        busy;
  logic        done;
  logic [31:0] data_out;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  sh;
    logic [31:0] din;
    logic [31:0] exp;
  } vec_t;
  vec_t vec[10];

  mips_seq_shifter #(.WIDTH(32), .SHAMT_W(5), .STEP(4)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .shamt(shamt),
    .data_in(data_in), .busy(busy), .done(done), .data_out(data_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [31:0] ref_shift(logic [1:0] o, logic [4:0] s, logic [31:0] d);
    logic signed [31:0] sd;
    sd = d;
    case (o)
      2'b00: return d << s;
      2'b10: return $unsigned(sd >>> s);
`ifdef MIPS_SEQ_SHIFTER_ROTATE_EN
      2'b11: return (d >> s) | (d << (32 - int'(s)));
`else
      2'b11: return d >> s;
`endif
      default: return d >> s;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a start in the current cycle t; result expected in cycle t+1+ceil(shamt/4).
  task automatic issue(logic [1:0] o, logic [4:0] s, logic [31:0] d, logic [31:0] e);
    sb_t ent;
    op      = o;
    shamt   = s;
    data_in = d;
    start   = 1'b1;
    ent.data = e;
    ent.cyc  = cyc + 1 + (int'(s) + 3) / 4;
    sb_q.push_back(ent);
    tick();
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb_q.size() != 0; i++) tick();
    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results still pending", sb_q.size());
      sb_q.delete();
    end
    tick();
  endtask

  // Scoreboard monitor, sampling mid-cycle.
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      if (!reset && done) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: data_out %h at cycle %0d", data_out, cyc);
        end else begin
          e = sb_q.pop_front();
          chk("data_out", data_out, e.data);
          chk("done_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    logic [1:0]  ro;
    logic [4:0]  rs;
    logic [31:0] rd;

    vec[0] = '{2'b00, 5'd2,  32'h0000_0001, 32'h0000_0004};
    vec[1] = '{2'b10, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF};
    vec[2] = '{2'b01, 5'd31, 32'h8000_0000, 32'h0000_0001};
    vec[3] = '{2'b00, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vec[4] = '{2'b00, 5'd31, 32'h0000_0003, 32'h8000_0000};
    vec[5] = '{2'b10, 5'd4,  32'h7000_0000, 32'h0700_0000};
    vec[6] = '{2'b10, 5'd5,  32'hF000_0010, 32'hFF80_0000};
    vec[7] = '{2'b01, 5'd1,  32'hFFFF_FFFF, 32'h7FFF_FFFF};
`ifdef MIPS_SEQ_SHIFTER_ROTATE_EN
    vec[8] = '{2'b11, 5'd8,  32'h1234_5678, 32'h7812_3456};
    vec[9] = '{2'b11, 5'd3,  32'h0000_0005, 32'hA000_0000};
`else
    vec[8] = '{2'b11, 5'd8,  32'h1234_5678, 32'h0012_3456};
    vec[9] = '{2'b11, 5'd3,  32'h0000_0005, 32'h0000_0000};
`endif

    reset = 1'b1; start = 1'b0; op = 2'b00; shamt = '0; data_in = '0;
    repeat (3) tick();
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_data_out", data_out, 32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) begin
      issue(vec[i].op, vec[i].sh, vec[i].din, vec[i].exp);
      drain();
    end

    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 3));
      rs = 5'($urandom_range(0, 31));
      rd = $urandom;
      issue(ro, rs, rd, ref_shift(ro, rs, rd));
      drain();
    end

    // SLL by 2: busy in t+1, done only in t+2.
    issue(2'b00, 5'd2, 32'h0000_0001, 32'h0000_0004);
    chk("sll2_busy_t1", {31'd0, busy}, 32'd1);
    chk("sll2_done_t1", {31'd0, done}, 32'd0);
    drain();

    // shamt 0: straight to DONE, busy never seen.
    issue(2'b00, 5'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    chk("sh0_busy_t1", {31'd0, busy}, 32'd0);
    tick();
    chk("sh0_busy_t2", {31'd0, busy}, 32'd0);
    drain();

    // Start during SHIFT is ignored, then a back-to-back start in the DONE cycle.
    issue(2'b00, 5'd8, 32'h0000_000F, 32'h0000_0F00);
    op = 2'b01; shamt = 5'd4; data_in = 32'hAAAA_5555; start = 1'b1;
    tick();
    start = 1'b0;
    chk("ignored_busy_t2", {31'd0, busy}, 32'd1);
    tick();
    chk("b2b_done_t3", {31'd0, done}, 32'd1);
    issue(2'b01, 5'd4, 32'h0000_00F0, 32'h0000_000F);
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    chk("b2b_data_hold", data_out, 32'h0000_0F00);
    drain();

    // Reset in the middle of an SRA by 20 aborts with no result.
    issue(2'b10, 5'd20, 32'h8000_0000, 32'hFFFF_F800);
    tick();
    reset = 1'b1;
    tick();
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_data_out", data_out, 32'd0);
    sb_q.delete();
    reset = 1'b0;
    tick();
    issue(2'b10, 5'd20, 32'h8000_0000, 32'hFFFF_F800);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

endmodule

// File: doc/mips_seq_shifter.md
Name: mips_seq_shifter

Overview:
- Parametrised multi-cycle shifter for the MIPS EX stage.
- Generalises the fixed shift-left-by-2 offset path to variable amount, variable width and four modes.
- Serves SLL/SRL/SRA/SLLV/SRLV/SRAV and address-offset scaling.
- Shifts up to STEP bits per cycle under a start/busy/done handshake, trading latency for area relative to a full barrel shifter.

Parameters:
- WIDTH, 32, datapath width in bits.
- SHAMT_W, 5, shift-amount width; must equal clog2(WIDTH).
- STEP, 4, maximum bits shifted per cycle; power of two, 1..WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE or DONE.
- op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROTR (see Optional Feature).
- shamt  input  SHAMT_W  shift amount, 0..WIDTH-1.
- data_in  input  WIDTH  operand, captured on accepted start.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse when result valid.
- data_out  output  WIDTH  result register; holds value until next accepted start completes.

Behaviour:
- Clock and reset: one clock (clk). reset is synchronous and active-high; it is sampled on the rising edge of clk.
- Reset state: state=IDLE, busy=0, done=0, data_out=0, internal remaining count=0.
- Reset mid-operation: the operation is aborted with no partial result. The state above holds from the next edge.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, start=1: latch data_in into the work register, and latch op and shamt into remaining.
  - shamt==0 goes to DONE.
  - Otherwise goes to SHIFT.
- SHIFT, each cycle:
  - amt = min(remaining, STEP).
  - Apply a shift of amt per the latched op.
  - remaining -= amt.
  - When the updated remaining==0, copy the work register to data_out and go to DONE.
- DONE: done=1 for exactly this cycle.
  - start=1 is accepted exactly as in IDLE, allowing back-to-back operation.
  - Otherwise go to IDLE.
- start during SHIFT is ignored; no queueing, no error flag.
- Latency: a start accepted at the edge ending cycle t gives done=1 in cycle t+1+ceil(shamt/STEP).
  - With WIDTH=32, STEP=4 the worst case is t+9.
- shamt==0: data_out=data_in; done in cycle t+1.
- Shift semantics:
  - SLL fills with zeros from the LSB.
  - SRL fills with zeros from the MSB.
  - SRA replicates the latched operand's bit WIDTH-1 on every step.
  - Bits shifted out are discarded.
- Result equals the single-step shift by shamt for every op; the composition of partial shifts must be exact.
- busy = (state==SHIFT); it is registered-state derived, with no combinational path from start.
- data_out changes only on the DONE transition or on reset; it is stable while busy.
- The work register is not visible externally.

Optional Feature:
- Macro: MIPS_SEQ_SHIFTER_ROTATE_EN.
- Defined: op=11 performs rotate-right (MIPS32r2 ROTR/ROTRV); bits leaving the LSB re-enter at the MSB. Latency is the same as the other ops.
- Not defined: op=11 is decoded as SRL, and no rotate logic is synthesised.

Test Plan:
- SLL, data_in=0x00000001, shamt=2, start at t -> data_out=0x00000004, done=1 at t+2 only, busy=1 at t+1.
- SRA, data_in=0x80000000, shamt=31 -> data_out=0xFFFFFFFF, done at t+9. Also SRL on the same input -> 0x00000001.
- shamt=0, data_in=0xDEADBEEF, op=SLL -> data_out=0xDEADBEEF, done at t+1, busy never asserted.
- Start SLL 0x0000000F shamt=8; pulse start with different data at t+1 -> ignored; result 0x00000F00 at t+3. Then back-to-back start in the DONE cycle is accepted.
- Start SRA with shamt=20; assert reset at t+2 -> busy=0, done=0, data_out=0 next cycle. A new start after reset behaves normally.
- With MIPS_SEQ_SHIFTER_ROTATE_EN: op=11, 0x12345678, shamt=8 -> 0x78123456.
- Without MIPS_SEQ_SHIFTER_ROTATE_EN: op=11, 0x12345678, shamt=8 -> 0x00123456.
